// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Prefetch behaviour is selected in fetch_unit by the FETCH_PREFETCH_EN macro.
package fetch_unit_pkg;

  localparam int          FETCH_REG_WIDTH = 32;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
  localparam int          FETCH_PC_STEP   = 4;

  // Encodings are shared with the legacy DEFINES.v state values.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures memory words and hands them to decode.
// Define FETCH_PREFETCH_EN to go straight back to S_RESP after a handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   REG_WIDTH = FETCH_REG_WIDTH,
  parameter logic [REG_WIDTH-1:0] RESET_PC  = REG_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [REG_WIDTH-1:0] pc_o,
  input  logic [REG_WIDTH-1:0] ir_i,
  input  logic                 redirect_valid,
  input  logic [REG_WIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [REG_WIDTH-1:0] inst_o,
  output logic [REG_WIDTH-1:0] inst_pc_o,
  output logic                 misalign_err
);

`ifdef FETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  fetch_state_e         state_reg, state_next;
  logic [REG_WIDTH-1:0] pc_reg, pc_next;
  logic [REG_WIDTH-1:0] inst_reg, inst_next;
  logic [REG_WIDTH-1:0] inst_pc_reg, inst_pc_next;
  logic                 valid_reg, valid_next;
  logic                 err_reg, err_next;

  logic                 handshake;
  logic [REG_WIDTH-1:0] pc_inc;

  assign handshake = valid_reg & inst_ready;
  assign pc_inc    = pc_reg + REG_WIDTH'(FETCH_PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_REQ;
      pc_reg      <= RESET_PC;
      inst_reg    <= '0;
      inst_pc_reg <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
    valid_next   = valid_reg;
    err_next     = err_reg;

    // A redirect squashes whatever is in flight, including a coincident handshake.
    if (redirect_valid) begin
      state_next = S_REQ;
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      if (is_misaligned(redirect_pc[1:0])) begin
        err_next = 1'b1;
      end
    end else begin
      case (state_reg)
        S_REQ: begin
          state_next = S_RESP;
        end
        S_RESP: begin
          inst_next    = ir_i;
          inst_pc_next = pc_reg;
          valid_next   = 1'b1;
          pc_next      = pc_inc;
          state_next   = S_HOLD;
        end
        S_HOLD: begin
          // pc_reg already points at the next word, so prefetch can skip S_REQ.
          if (handshake) begin
            valid_next = 1'b0;
            state_next = PREFETCH ? S_RESP : S_REQ;
          end
        end
        default: begin
          state_next = S_REQ;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = pc_reg;
  assign inst_valid   = valid_reg;
  assign inst_o       = inst_reg;
  assign inst_pc_o    = inst_pc_reg;
  assign misalign_err = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a forked monitor pops expected words on each decode transfer.
// A second instance with RESET_PC=0xFFFF_FFFC covers PC wrap-around.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int EXP_SPACING = 2;
`else
  localparam int EXP_SPACING = 3;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o, ir_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_o, inst_pc_o;
  logic        misalign_err;

  logic [31:0] pc_w, ir_w, inst_w, inst_pc_w;
  logic        valid_w, err_w;

  logic [31:0] mem [0:63];
  exp_t        sb_q[$];
  exp_t        wrap_q[$];

  int tests;
  int fails;
  int xfer_cnt;
  int cyc;
  int c0, c1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ir_i <= mem[pc_o[7:2]];
    ir_w <= mem[pc_w[7:2]];
    cyc  <= cyc + 1;
  end

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .ir_i(ir_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .misalign_err(misalign_err)
  );

  fetch_unit #(.REG_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .pc_o(pc_w), .ir_i(ir_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(valid_w), .inst_ready(1'b1),
    .inst_o(inst_w), .inst_pc_o(inst_pc_w), .misalign_err(err_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("xfer_count_reached", 32'(xfer_cnt), 32'(target));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!inst_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_within_budget", {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic measure_latency(input string name);
    int n = 0;
    while (!inst_valid && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'd2);
  endtask

  initial begin
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tests = 0; fails = 0; xfer_cnt = 0; cyc = 0; c0 = 0; c1 = 0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    for (int k = 2; k < 64; k++) mem[k] = 32'hA000_0000 | 32'(k);

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
          xfer_cnt++;
          if (xfer_cnt == 1) c0 = cyc;
          if (xfer_cnt == 2) c1 = cyc;
          $display("[TB] xfer %0d pc=%h inst=%h", xfer_cnt, inst_pc_o, inst_o);
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_xfer: got pc=%h, expected no transfer", inst_pc_o);
          end else begin
            e = sb_q.pop_front();
            check("xfer_inst", inst_o, e.inst);
            check("xfer_pc", inst_pc_o, e.pc);
          end
        end
      end
      forever begin
        exp_t w;
        @(negedge clk);
        if (!rst && valid_w && wrap_q.size() != 0) begin
          w = wrap_q.pop_front();
          $display("[TB] wrap xfer pc=%h inst=%h", inst_pc_w, inst_w);
          check("wrap_inst", inst_w, w.inst);
          check("wrap_pc", inst_pc_w, w.pc);
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_inst_pc", inst_pc_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);
    check("rst_wrap_pc", pc_w, 32'hFFFF_FFFC);

    sb_q.push_back('{inst: 32'h0050_0093, pc: 32'h0000_0000});
    sb_q.push_back('{inst: 32'h0010_0113, pc: 32'h0000_0004});
    sb_q.push_back('{inst: 32'hA000_0002, pc: 32'h0000_0008});
    sb_q.push_back('{inst: 32'hA000_0003, pc: 32'h0000_000C});
    wrap_q.push_back('{inst: 32'hA000_003F, pc: 32'hFFFF_FFFC});
    wrap_q.push_back('{inst: 32'h0050_0093, pc: 32'h0000_0000});

    // Free run with decode always ready
    @(posedge clk); #1 rst = 1'b0;
    measure_latency("first_latency");
    wait_xfers(3, 40);
    @(posedge clk); #1 inst_ready = 1'b0;
    check("spacing", 32'(c1 - c0), 32'(EXP_SPACING));

    // Backpressure: word at 0xC held for 5 cycles, then exactly one transfer
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, inst_valid}, 32'd1);
      check("bp_inst", inst_o, 32'hA000_0003);
      check("bp_pc", inst_pc_o, 32'h0000_000C);
      @(negedge clk);
    end
    check("bp_no_xfer", 32'(xfer_cnt), 32'd3);
    @(posedge clk); #1 inst_ready = 1'b1;
    @(posedge clk); #1 inst_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("bp_one_xfer", 32'(xfer_cnt), 32'd4);
    check("held_pc16", inst_pc_o, 32'h0000_0010);

    // Redirect to 0x40 coinciding with a handshake in S_HOLD
    @(posedge clk); #1;
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    sb_q.push_back('{inst: 32'hA000_0010, pc: 32'h0000_0040});
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid_drop", {31'b0, inst_valid}, 32'd0);
    check("redir_pc", pc_o, 32'h0000_0040);
    wait_xfers(5, 20);
    @(posedge clk); #1 inst_ready = 1'b0;
    check("aligned_no_err", {31'b0, misalign_err}, 32'd0);

    // Misaligned redirect to 0x42: memory ignores the low bits
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    sb_q.push_back('{inst: 32'hA000_0010, pc: 32'h0000_0042});
    sb_q.push_back('{inst: 32'hA000_0011, pc: 32'h0000_0046});
    @(posedge clk); #1 redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    check("misalign_set", {31'b0, misalign_err}, 32'd1);
    wait_xfers(7, 30);
    @(posedge clk); #1 inst_ready = 1'b0;
    check("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // Reset while holding a valid instruction
    wait_valid(10);
    check("hold_pc4a", inst_pc_o, 32'h0000_004A);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'b0, inst_valid}, 32'd0);
    check("midrst_pc", pc_o, 32'h0000_0000);
    check("midrst_err", {31'b0, misalign_err}, 32'd0);
    check("midrst_inst", inst_o, 32'h0);
    check("midrst_inst_pc", inst_pc_o, 32'h0);
    measure_latency("restart_latency");
    check("restart_inst", inst_o, 32'h0050_0093);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("wrap_drained", 32'(wrap_q.size()), 32'd0);
    check("total_xfers", 32'(xfer_cnt), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
